// File: rtl/cnn_layer2_fmap_streamer.sv
// cnn_layer2_fmap_streamer: buffers one 4-channel layer-1 feature map and replays it once per layer-2 phase.
// Optional macro CNN_FMAP_STREAM_LINE_GAP_EN inserts one idle cycle after every line except the last.
module cnn_layer2_fmap_streamer #(
  parameter int DW        = 24,
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 16,
  parameter int PIX_CNT_W = 8,
  parameter int N_PHASE   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_valid,
  input  logic [DW-1:0]              i_wr_din0,
  input  logic [DW-1:0]              i_wr_din1,
  input  logic [DW-1:0]              i_wr_din2,
  input  logic [DW-1:0]              i_wr_din3,
  input  logic                       i_wr_last,
  input  logic                       i_conv_last_pix,
  input  logic                       i_layer_last_pix,
  output logic [DW-1:0]              o_dout0,
  output logic [DW-1:0]              o_dout1,
  output logic [DW-1:0]              o_dout2,
  output logic [DW-1:0]              o_dout3,
  output logic                       o_dout_valid,
  output logic                       o_squeeze,
  output logic [$clog2(N_PHASE)-1:0] o_phase_sel,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = $clog2(N_PHASE);
  localparam logic [PIX_CNT_W-1:0] LAST = PIX_CNT_W'(NPIX - 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [PIX_CNT_W-1:0] r_wr_cnt, r_rd_cnt;
  logic [PW-1:0]        r_phase;
  logic [4*DW-1:0]      r_mem [NPIX];
  logic [4*DW-1:0]      r_dout;
  logic r_dout_valid, r_squeeze, r_err, r_gap;
  logic w_accept, w_wr, w_rd, w_rd_last, w_load_ok, w_gap_next;
  assign w_accept  = r_state == S_IDLE || r_state == S_LOAD;
  assign w_wr      = i_wr_valid && w_accept;
  assign w_rd      = r_state == S_STREAM && !r_gap;
  assign w_rd_last = w_rd && r_rd_cnt == LAST;
  assign w_load_ok = r_state == S_LOAD && r_wr_cnt == LAST;
`ifdef CNN_FMAP_STREAM_LINE_GAP_EN
  assign w_gap_next = w_rd && !w_rd_last && (32'(r_rd_cnt) % WIDTH) == WIDTH - 1;
`else
  assign w_gap_next = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (i_wr_valid && !i_wr_last) ? S_LOAD : S_IDLE;
      S_LOAD:   w_next = !(i_wr_valid && i_wr_last) ? S_LOAD : w_load_ok ? S_STREAM : S_IDLE;
      S_STREAM: w_next = w_rd_last ? S_FLUSH : S_STREAM;
      S_FLUSH:  w_next = i_conv_last_pix ? S_DRAIN : S_FLUSH;
      S_DRAIN:  w_next = !i_layer_last_pix ? S_DRAIN : r_phase == PW'(N_PHASE - 1) ? S_DONE : S_STREAM;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // Buffer storage is never reset; a fresh load always overwrites every address before it is read.
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_state == S_IDLE ? '0 : r_wr_cnt] <= {i_wr_din3, i_wr_din2, i_wr_din1, i_wr_din0};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_phase      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_squeeze    <= 1'b0;
      r_err        <= 1'b0;
      r_gap        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wr)
        r_wr_cnt <= (r_state == S_IDLE && !i_wr_last) ? PIX_CNT_W'(1) : i_wr_last ? '0 :
                    r_wr_cnt == LAST ? r_wr_cnt : r_wr_cnt + 1'b1;
      r_rd_cnt     <= (w_next == S_STREAM && r_state != S_STREAM) ? '0 : w_rd ? r_rd_cnt + 1'b1 : r_rd_cnt;
      r_gap        <= w_gap_next;
      r_phase      <= r_state == S_DONE ? '0 : (r_state == S_DRAIN && w_next == S_STREAM) ? r_phase + 1'b1 : r_phase;
      r_dout_valid <= w_rd;
      if (w_rd) r_dout <= r_mem[r_rd_cnt];
      r_squeeze    <= r_state == S_FLUSH && !i_conv_last_pix;
      r_err        <= r_err | (i_wr_valid && (!w_accept || (i_wr_last && !w_load_ok)));
    end
  end
  assign o_dout0      = r_dout[DW-1:0];
  assign o_dout1      = r_dout[2*DW-1:DW];
  assign o_dout2      = r_dout[3*DW-1:2*DW];
  assign o_dout3      = r_dout[4*DW-1:3*DW];
  assign o_dout_valid = r_dout_valid;
  assign o_squeeze    = r_squeeze;
  assign o_phase_sel  = r_phase;
  assign o_busy       = r_state != S_IDLE;
  assign o_done       = r_state == S_DONE;
  assign o_err        = r_err;
endmodule

// File: tb/tb_cnn_layer2_fmap_streamer.sv
// tb_cnn_layer2_fmap_streamer: directed bench for the layer-2 feature-map streamer.
module tb_cnn_layer2_fmap_streamer;
  localparam int DW = 24;
`ifdef CNN_FMAP_STREAM_LINE_GAP_EN
  localparam int SPAN = 271;
`else
  localparam int SPAN = 256;
`endif
  logic clk = 0, rst_n = 0, wr_valid = 0, wr_last = 0, conv = 0, layer = 0;
  logic [DW-1:0] din [4];
  logic [DW-1:0] d0, d1, d2, d3;
  logic dv, sq, busy, done, err;
  logic [2:0] ph_sel;
  typedef struct {int pix; int ch; logic [DW-1:0] exp;} vec_t;
  vec_t tbl [6];
  int nvec = 0, nmiss = 0;
  logic inj = 0, clr = 0, prev_sq = 0;
  logic [4*DW-1:0] cap [8][256];
  int vcnt [8], first_v [8], last_v [8], sq_rise [8];
  int ncyc = 0, ndone = 0, vtot = 0;

  cnn_layer2_fmap_streamer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid),
    .i_wr_din0(din[0]), .i_wr_din1(din[1]), .i_wr_din2(din[2]), .i_wr_din3(din[3]),
    .i_wr_last(wr_last), .i_conv_last_pix(conv), .i_layer_last_pix(layer),
    .o_dout0(d0), .o_dout1(d1), .o_dout2(d2), .o_dout3(d3),
    .o_dout_valid(dv), .o_squeeze(sq), .o_phase_sel(ph_sel),
    .o_busy(busy), .o_done(done), .o_err(err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc++;
    if (clr) begin
      for (int p = 0; p < 8; p++) begin
        vcnt[p] = 0; first_v[p] = 0; last_v[p] = 0; sq_rise[p] = 0;
        for (int a = 0; a < 256; a++) cap[p][a] = '0;
      end
      ndone = 0; vtot = 0; prev_sq = 0;
    end else begin
      if (dv) begin
        if (vcnt[ph_sel] == 0) first_v[ph_sel] = ncyc;
        last_v[ph_sel] = ncyc;
        cap[ph_sel][vcnt[ph_sel] % 256] = {d3, d2, d1, d0};
        vcnt[ph_sel]++;
        vtot++;
      end
      if (sq && !prev_sq) sq_rise[ph_sel] = ncyc;
      prev_sq = sq;
      if (done) ndone++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1;
      wr_last  = (i == last_at);
      for (int c = 0; c < 4; c++) din[c] = DW'(c * 'h1000 + i);
      cyc();
    end
    wr_valid = 0;
    wr_last  = 0;
  endtask

  task automatic wait_sq();
    for (int k = 0; k < 2000 && !sq; k++) cyc();
    chk("squeeze rise", 32'(sq), 1);
  endtask

  task automatic serve(input int n);
    for (int p = 0; p < n; p++) begin
      if (inj && p == 3) begin
        repeat (20) cyc();
        chk("err before stray write", 32'(err), 0);
        wr_valid = 1;
        for (int c = 0; c < 4; c++) din[c] = 24'hABCDEF;
        cyc();
        wr_valid = 0;
        chk("err after stray write", 32'(err), 1);
      end
      wait_sq();
      chk("phase during flush", 32'(ph_sel), p);
      repeat (19) cyc();
      conv = 1;
      cyc();
      conv = 0;
      chk("squeeze after conv_last", 32'(sq), 0);
      repeat (49) cyc();
      layer = 1;
      cyc();
      layer = 0;
      if (p < 7) chk("phase advance", 32'(ph_sel), p + 1);
      else chk("done pulse", 32'(done), 1);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 24'h000000};
    tbl[1] = '{37, 2, 24'h002025};
    tbl[2] = '{255, 3, 24'h0030FF};
    tbl[3] = '{128, 1, 24'h001080};
    tbl[4] = '{16, 0, 24'h000010};
    tbl[5] = '{200, 3, 24'h0030C8};
    for (int c = 0; c < 4; c++) din[c] = '0;
    clr = 1;
    repeat (2) cyc();
    chk("reset dout_valid", 32'(dv), 0);
    chk("reset squeeze", 32'(sq), 0);
    chk("reset phase", 32'(ph_sel), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset err", 32'(err), 0);
    chk("reset dout0", 32'(d0), 0);
    rst_n = 1;
    cyc();
    clr = 0;
    // full eight-phase run with a stray write during phase 3
    inj = 1;
    load(256, 255);
    serve(8);
    inj = 0;
    cyc();
    chk("busy after done", 32'(busy), 0);
    chk("done single cycle", 32'(done), 0);
    chk("done count", ndone, 1);
    chk("total valid", vtot, 2048);
    for (int p = 0; p < 8; p++) begin
      chk("phase valid count", vcnt[p], 256);
      chk("phase span", last_v[p] - first_v[p] + 1, SPAN);
      chk("squeeze after last valid", sq_rise[p] - last_v[p], 1);
    end
    for (int k = 0; k < 3; k++) begin
      int p;
      p = (k == 0) ? 0 : (k == 1) ? 3 : 7;
      for (int r = 0; r < 6; r++)
        chk($sformatf("dout ph%0d pix%0d ch%0d", p, tbl[r].pix, tbl[r].ch),
            32'(cap[p][tbl[r].pix][tbl[r].ch*DW +: DW]), 32'(tbl[r].exp));
    end
    // short map, then a good map, then reset mid phase 5
    rst_n = 0;
    cyc();
    rst_n = 1;
    clr = 1;
    cyc();
    clr = 0;
    chk("err cleared by reset", 32'(err), 0);
    load(101, 100);
    chk("err on short map", 32'(err), 1);
    chk("idle after short map", 32'(busy), 0);
    repeat (5) cyc();
    chk("no stream after short map", vtot, 0);
    load(256, 255);
    serve(5);
    chk("err sticky", 32'(err), 1);
    chk("phase0 count after reload", vcnt[0], 256);
    chk("reload pix37 ch2", 32'(cap[0][37][2*DW +: DW]), 32'h002025);
    for (int k = 0; k < 2000 && vcnt[5] < 128; k++) cyc();
    chk("phase 5 reached", 32'(vcnt[5] >= 128), 1);
    rst_n = 0;
    #1;
    chk("async rst dout_valid", 32'(dv), 0);
    chk("async rst phase", 32'(ph_sel), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst err", 32'(err), 0);
    chk("async rst squeeze", 32'(sq), 0);
    chk("async rst dout2", 32'(d2), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    clr = 1;
    cyc();
    clr = 0;
    load(256, 255);
    chk("restart phase", 32'(ph_sel), 0);
    chk("restart busy", 32'(busy), 1);
    wait_sq();
    chk("restart flush phase", 32'(ph_sel), 0);
    chk("restart valid count", vcnt[0], 256);
    chk("restart total valid", vtot, 256);
    chk("restart pix37 ch2", 32'(cap[0][37][2*DW +: DW]), 32'h002025);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
